// File: rtl/exu_bp_upd_q.sv
// exu_bp_upd_q: branch-predictor update queue between ALU resolution and the BHT write port.
// Resolved branches are buffered in a small circular FIFO and drained via valid/ready.
// Overflow discards the newest update and bumps a saturating drop counter.
// Optional feature macro: EXU_BPQ_BYPASS_EN (zero-latency pass-through when empty).
module exu_bp_upd_q #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDXW  = 8
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            freeze,
  input  logic            flush,
  input  logic            res_valid,
  input  logic [IDXW-1:0] res_index,
  input  logic [1:0]      res_hist,
  input  logic            res_ataken,
  input  logic            res_misp,
  input  logic            res_way,
  output logic            upd_valid,
  input  logic            upd_ready,
  output logic [IDXW-1:0] upd_index,
  output logic [1:0]      upd_hist,
  output logic            upd_ataken,
  output logic            upd_misp,
  output logic            upd_way,
  output logic            full,
  output logic            empty,
  output logic            dropped,
  output logic [7:0]      drop_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [IDXW-1:0] index;
    logic [1:0]      hist;
    logic            ataken;
    logic            misp;
    logic            way;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [7:0]      drop_cnt_q;

  entry_t          res_entry;
  entry_t          head;
  logic            q_empty;
  logic            q_full;
  logic            push_c;
  logic            pop_c;
  logic            byp_c;
  logic            byp_take_c;
  logic            wr_en_c;
  logic            rd_adv_c;
  logic            drop_c;

  // Incoming resolution packed into a queue entry.
  always_comb begin
    res_entry        = '0;
    res_entry.index  = res_index;
    res_entry.hist   = res_hist;
    res_entry.ataken = res_ataken;
    res_entry.misp   = res_misp;
    res_entry.way    = res_way;
  end

  assign q_empty = (count_q == CW'(0));
  assign q_full  = (count_q == CW'(DEPTH));
  assign push_c  = res_valid & ~flush & ~freeze;

`ifdef EXU_BPQ_BYPASS_EN
  // Empty queue with a push: present the input directly to the BHT port.
  assign byp_c = push_c & q_empty;
`else
  assign byp_c = 1'b0;
`endif

  // Head selection, handshake and queue-update decisions.
  always_comb begin
    head       = mem[rd_ptr_q];
    upd_valid  = ~q_empty;
    if (byp_c) begin
      head      = res_entry;
      upd_valid = 1'b1;
    end
    pop_c      = upd_valid & upd_ready & ~freeze;
    // A bypassed entry consumed this cycle never touches storage.
    byp_take_c = byp_c & pop_c;
    wr_en_c    = push_c & (~q_full | pop_c) & ~byp_take_c;
    rd_adv_c   = pop_c & ~byp_take_c;
    drop_c     = push_c & q_full & ~pop_c;
  end

  assign upd_index  = head.index;
  assign upd_hist   = head.hist;
  assign upd_ataken = head.ataken;
  assign upd_misp   = head.misp;
  assign upd_way    = head.way;
  assign full       = q_full;
  assign empty      = q_empty;
  assign dropped    = drop_c;
  assign drop_cnt   = drop_cnt_q;

  // Entry storage; deliberately not reset, contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_ptr_q] <= res_entry;
    end
  end

  // Pointers, occupancy and saturating drop counter.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (wr_en_c) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (rd_adv_c) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({wr_en_c, rd_adv_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (drop_c && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_exu_bp_upd_q.sv
// tb_exu_bp_upd_q: directed self-checking bench for exu_bp_upd_q (DEPTH=4, IDXW=8).
// Honors EXU_BPQ_BYPASS_EN for the first-transaction latency expectations.
module tb_exu_bp_upd_q;

  logic       clk;
  logic       rst_l;
  logic       freeze;
  logic       flush;
  logic       res_valid;
  logic [7:0] res_index;
  logic [1:0] res_hist;
  logic       res_ataken;
  logic       res_misp;
  logic       res_way;
  logic       upd_valid;
  logic       upd_ready;
  logic [7:0] upd_index;
  logic [1:0] upd_hist;
  logic       upd_ataken;
  logic       upd_misp;
  logic       upd_way;
  logic       full;
  logic       empty;
  logic       dropped;
  logic [7:0] drop_cnt;

  int n_err;
  int n_chk;

  exu_bp_upd_q #(.DEPTH(4), .IDXW(8)) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .freeze     (freeze),
    .flush      (flush),
    .res_valid  (res_valid),
    .res_index  (res_index),
    .res_hist   (res_hist),
    .res_ataken (res_ataken),
    .res_misp   (res_misp),
    .res_way    (res_way),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_index  (upd_index),
    .upd_hist   (upd_hist),
    .upd_ataken (upd_ataken),
    .upd_misp   (upd_misp),
    .upd_way    (upd_way),
    .full       (full),
    .empty      (empty),
    .dropped    (dropped),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one entry with upd_ready left as the caller set it.
  task automatic push(input logic [7:0] idx);
    res_valid = 1'b1;
    res_index = idx;
    res_hist  = idx[1:0];
    tick();
    res_valid = 1'b0;
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    rst_l = 1'b0; freeze = 1'b0; flush = 1'b0;
    res_valid = 1'b0; res_index = '0; res_hist = '0;
    res_ataken = 1'b0; res_misp = 1'b0; res_way = 1'b0;
    upd_ready = 1'b0;
    tick();
    tick();
    rst_l = 1'b1;
    #1;
    chk("rst_valid", 32'(upd_valid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_dropped", 32'(dropped), 32'd0);
    chk("rst_dcnt", 32'(drop_cnt), 32'd0);

    // Single push 0x3A, hist 10, misp 1, way 1 with the BHT ready.
    res_valid = 1'b1; res_index = 8'h3A; res_hist = 2'b10;
    res_misp = 1'b1; res_way = 1'b1; upd_ready = 1'b1;
    #1;
`ifdef EXU_BPQ_BYPASS_EN
    chk("byp_valid", 32'(upd_valid), 32'd1);
    chk("byp_index", 32'(upd_index), 32'h3A);
    chk("byp_hist", 32'(upd_hist), 32'd2);
    chk("byp_misp", 32'(upd_misp), 32'd1);
    tick();
    res_valid = 1'b0; res_misp = 1'b0; res_way = 1'b0;
    #1;
    chk("byp_empty", 32'(empty), 32'd1);
    chk("byp_valid_after", 32'(upd_valid), 32'd0);
`else
    chk("q0_valid_early", 32'(upd_valid), 32'd0);
    tick();
    res_valid = 1'b0; res_misp = 1'b0; res_way = 1'b0;
    #1;
    chk("q1_valid", 32'(upd_valid), 32'd1);
    chk("q1_index", 32'(upd_index), 32'h3A);
    chk("q1_hist", 32'(upd_hist), 32'd2);
    chk("q1_misp", 32'(upd_misp), 32'd1);
    chk("q1_way", 32'(upd_way), 32'd1);
    tick();
    chk("q2_empty", 32'(empty), 32'd1);
`endif

    // Overflow: five pushes into a 4-deep queue with the BHT stalled.
    upd_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      res_valid = 1'b1;
      res_index = 8'(i);
      res_hist  = 2'(i);
      #1;
      chk($sformatf("ovf_dropped_%0d", i), 32'(dropped), (i == 5) ? 32'd1 : 32'd0);
      if (i == 5) chk("ovf_full4", 32'(full), 32'd1);
      tick();
    end
    res_valid = 1'b0;
    #1;
    chk("ovf_dcnt", 32'(drop_cnt), 32'd1);
    chk("ovf_full", 32'(full), 32'd1);
    upd_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("drain_valid_%0d", k), 32'(upd_valid), 32'd1);
      chk($sformatf("drain_idx_%0d", k), 32'(upd_index), 32'(k));
      chk($sformatf("drain_hist_%0d", k), 32'(upd_hist), 32'(k % 4));
      tick();
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Full queue, simultaneous push/pop, then continuous streaming across wrap.
    upd_ready = 1'b0;
    for (int i = 10; i <= 13; i++) push(8'(i));
    res_valid = 1'b1; res_index = 8'd14; upd_ready = 1'b1;
    #1;
    chk("pp_dropped", 32'(dropped), 32'd0);
    chk("pp_head", 32'(upd_index), 32'd10);
    tick();
    chk("pp_full", 32'(full), 32'd1);
    for (int k = 0; k < 12; k++) begin
      res_index = 8'(15 + k);
      #1;
      chk($sformatf("wrap_idx_%0d", k), 32'(upd_index), 32'(11 + k));
      chk($sformatf("wrap_full_%0d", k), 32'(full), 32'd1);
      tick();
    end
    res_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("tail_idx_%0d", k), 32'(upd_index), 32'(23 + k));
      tick();
    end
    chk("tail_empty", 32'(empty), 32'd1);
    chk("tail_dcnt", 32'(drop_cnt), 32'd1);

    // Flush: kills the concurrent push but not entries already queued.
    upd_ready = 1'b0;
    flush = 1'b1;
    push(8'h41);
    chk("flush_empty", 32'(empty), 32'd1);
    flush = 1'b0;
    push(8'h40);
    flush = 1'b1;
    push(8'h42);
    flush = 1'b0;
    chk("flush_head", 32'(upd_index), 32'h40);
    upd_ready = 1'b1;
    tick();
    chk("flush_empty2", 32'(empty), 32'd1);

    // Freeze with a full queue: no push, no pop, no drop.
    upd_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'h50 + i));
    freeze = 1'b1; res_valid = 1'b1; res_index = 8'h5F; upd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("frz_dropped_%0d", k), 32'(dropped), 32'd0);
      tick();
    end
    freeze = 1'b0; res_valid = 1'b0; upd_ready = 1'b0;
    #1;
    chk("frz_head", 32'(upd_index), 32'h50);
    chk("frz_full", 32'(full), 32'd1);
    chk("frz_dcnt", 32'(drop_cnt), 32'd1);
    upd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("frz_drain_%0d", k), 32'(upd_index), 32'(8'h50 + k));
      tick();
    end
    chk("frz_empty", 32'(empty), 32'd1);

    // Saturate the drop counter, then reset mid-stream.
    upd_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'h60 + i));
    res_valid = 1'b1; res_index = 8'h70;
    for (int k = 0; k < 300; k++) begin
      if (k == 100) chk("sat_mid", 32'(drop_cnt), 32'd101);
      tick();
    end
    #1;
    chk("sat_dropped", 32'(dropped), 32'd1);
    chk("sat_dcnt", 32'(drop_cnt), 32'd255);
    upd_ready = 1'b1;
    rst_l = 1'b0;
    tick();
    res_valid = 1'b0;
    upd_ready = 1'b0;
    #1;
    chk("mrst_valid", 32'(upd_valid), 32'd0);
    chk("mrst_empty", 32'(empty), 32'd1);
    chk("mrst_full", 32'(full), 32'd0);
    chk("mrst_dcnt", 32'(drop_cnt), 32'd0);
    rst_l = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/exu_bp_upd_q.md
# exu_bp_upd_q

Branch-predictor update queue downstream of the ALU control stage. Each cycle the ALU resolves a branch, this block captures the resolution (BHT index, new 2-bit history, actual-taken, mispredict, way) into a small FIFO. It drains entries to the BHT write port through a valid/ready handshake, so a busy predictor array never stalls execute. Overflow drops the newest update and is counted.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, 2..16.
- IDXW, 8: BHT index width.

Ports:
- clk  in  1  top-level clock.
- rst_l  in  1  reset, synchronous, active-low.
- freeze  in  1  pipeline freeze; blocks push and pop.
- flush  in  1  kills a push in the same cycle.
- res_valid  in  1  branch resolved this cycle (ALU valid_ff & branch).
- res_index  in  IDXW  BHT index of the branch.
- res_hist  in  2  new history (predict_p_ff.hist).
- res_ataken  in  1  actual taken.
- res_misp  in  1  mispredict.
- res_way  in  1  BTB way.
- upd_valid  out  1  head entry available.
- upd_ready  in  1  BHT accepts the head entry this cycle.
- upd_index  out  IDXW  head index.
- upd_hist  out  2  head history.
- upd_ataken  out  1  head actual-taken.
- upd_misp  out  1  head mispredict.
- upd_way  out  1  head way.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- dropped  out  1  one-cycle pulse when a push is discarded because the queue is full.
- drop_cnt  out  8  saturating count of drops.

## Operation
- Push condition: res_valid & ~flush & ~freeze.
- Pop condition: upd_valid & upd_ready & ~freeze.
- Storage: DEPTH-entry circular buffer with wr_ptr and rd_ptr of log2(DEPTH) bits, wrapping modulo DEPTH, plus a count register of log2(DEPTH)+1 bits.
- Push when not full: write entry at wr_ptr, then increment wr_ptr.
- Push when full and no pop this cycle: discard the entry. Pulse dropped, increment drop_cnt saturating at 255, leave pointers unchanged.
- Simultaneous push and pop when full: both take effect, no drop, count unchanged.
- Simultaneous push and pop when not full: both take effect, count unchanged.
- Pop: increment rd_ptr. Output fields always reflect the entry at rd_ptr (or the bypassed input, see Configuration).
- flush does not discard entries already queued; they are architecturally resolved.
- Outputs are not masked when upd_valid = 0. The bench must ignore them in that case.
- Reset: pointers, count, and drop_cnt = 0. upd_valid = 0, empty = 1, full = 0, dropped = 0. Storage is not reset; outputs read as don't-care while empty.

## Timing
- Queued path: an entry pushed in cycle N is visible on upd_valid in N+1 if the queue was empty.
- Throughput: one push and one pop per cycle.
- full, empty, and upd_valid are registered state (derived from count), never combinational from res_valid, except under the bypass option.
- dropped is combinational from push & full & ~pop.
- freeze held: all state holds and dropped = 0.
- Reset asserted mid-operation: the queue empties on the next clock edge regardless of pending push or pop.

## Configuration
- EXU_BPQ_BYPASS_EN defined:
  - When the queue is empty and a push occurs, upd_valid and the upd_* fields are driven combinationally from the res_* inputs.
  - If upd_ready is high that cycle, the entry is consumed with zero latency and never written. Pointers and count are unchanged.
  - If upd_ready is low, the entry is written normally.
- EXU_BPQ_BYPASS_EN undefined: one-cycle minimum latency; all upd_* outputs come from storage.

## Test plan
- Reset, then single push of index 0x3A, hist 2'b10, misp 1, with upd_ready = 1:
  - Without bypass: upd_valid = 1 one cycle later with those values; empty returns to 1 after the pop.
  - With bypass: same values appear in the push cycle and the queue stays empty.
- upd_ready = 0; push 5 entries (index 1..5) at DEPTH = 4:
  - full = 1 after the 4th push.
  - 5th push pulses dropped and drop_cnt = 1.
  - Draining returns indices 1, 2, 3, 4 in order.
- Full queue, push and pop in the same cycle: no drop, count stays 4, the new entry emerges 4th. Then pop 12 more with continuous pushes; verify in-order delivery across pointer wrap.
- Push with flush = 1: no entry is queued and the queue stays empty. Queued entries present before the flush are still delivered intact.
- freeze = 1 for 3 cycles with res_valid = 1 and upd_ready = 1: no push, no pop, dropped = 0, and state is unchanged after freeze drops.
- Force 300 overflow pushes: drop_cnt saturates at 255. Assert rst_l = 0 mid-stream: on the next edge count = 0, drop_cnt = 0, upd_valid = 0.
